rtc_hms_counter: RTL

- Parametrised time-of-day counter: replaces the fixed 50 MHz, 24-hour-only seconds/minutes/hours counter.
- Holds time as BCD digit registers, so no divide/modulo logic is needed.
- Adds run/stop, a set interface, 12/24-hour display mode and an alarm match.
- Sits between the board clock and the existing 7-segment decoder instances; its digit outputs feed those decoders directly.

---
 rtl/rtc_hms_counter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rtc_hms_counter.sv
// rtc_hms_counter: time-of-day counter held as BCD digit pairs.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   run                       1 = timekeeping, 0 = stopped / set mode
//   load, ld_hr/min/sec       one-cycle load of a binary time (invalid loads dropped)
//   inc_hr, inc_min           set-mode field increments (no carry between fields)
//   mode_12h                  display selection, combinational only
//   alarm_en, alarm_hr/min    alarm compare against hh:mm:00
//   sec_lo .. hr_hi           BCD display digits
//   pm                        internal hour is 12..23
//   sec_tick, alarm           registered one-cycle pulses on a time advance
module rtc_hms_counter #(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned PRESC_W  = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       load,
   input  logic [4:0] ld_hr,
   input  logic [5:0] ld_min,
   input  logic [5:0] ld_sec,
   input  logic       inc_hr,
   input  logic       inc_min,
   input  logic       mode_12h,
   input  logic       alarm_en,
   input  logic [4:0] alarm_hr,
   input  logic [5:0] alarm_min,
   output logic [3:0] sec_lo,
   output logic [3:0] sec_hi,
   output logic [3:0] min_lo,
   output logic [3:0] min_hi,
   output logic [3:0] hr_lo,
   output logic [3:0] hr_hi,
   output logic       pm,
   output logic       sec_tick,
   output logic       alarm
);

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ - 1);

   // Binary 0..63 to {tens, units} by repeated subtraction; no divider.
   function automatic logic [7:0] toBcd(input logic [5:0] v);
      logic [3:0] hi;
      logic [5:0] rem;
      hi  = 4'd0;
      rem = v;
      for (int k = 0; k < 6; k++) begin
         if (rem >= 6'd10) begin
            rem = rem - 6'd10;
            hi  = hi + 4'd1;
         end
      end
      return {hi, rem[3:0]};
   endfunction

   function automatic logic [7:0] incMod60(input logic [7:0] v);
      if (v[3:0] == 4'd9)
         return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] incHr(input logic [7:0] v);
      if (v == 8'h23)      return 8'h00;
      if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   logic [PRESC_W-1:0] presc;
   logic [7:0] secR, minR, hrR;
   logic [7:0] advSec, advMin, advHr;
   logic [7:0] dispHr;
   logic       ldOk, tickDue, alarmHit;

   always_comb begin
      ldOk    = load && (ld_hr <= 5'd23) && (ld_min <= 6'd59) && (ld_sec <= 6'd59);
      tickDue = run && (presc == PRESC_MAX);
      // Next time after a one-second advance, ripple-carried through the pairs.
      advSec  = incMod60(secR);
      advMin  = (secR == 8'h59) ? incMod60(minR) : minR;
      advHr   = (secR == 8'h59 && minR == 8'h59) ? incHr(hrR) : hrR;
      alarmHit = alarm_en && (advSec == 8'h00) && (advMin == toBcd(alarm_min))
                 && (advHr == toBcd({1'b0, alarm_hr}));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc    <= '0;
         secR     <= 8'h00;
         minR     <= 8'h00;
         hrR      <= 8'h00;
         sec_tick <= 1'b0;
         alarm    <= 1'b0;
      end else begin
         sec_tick <= 1'b0;
         alarm    <= 1'b0;
         if (ldOk) begin
            // A valid load wins over any due tick, which is simply lost.
            secR  <= toBcd(ld_sec);
            minR  <= toBcd(ld_min);
            hrR   <= toBcd({1'b0, ld_hr});
            presc <= '0;
         end else if (!run) begin
            presc <= '0;
            if (inc_hr)  hrR  <= incHr(hrR);
            if (inc_min) minR <= incMod60(minR);
         end else if (tickDue) begin
            presc    <= '0;
            secR     <= advSec;
            minR     <= advMin;
            hrR      <= advHr;
            sec_tick <= 1'b1;
            alarm    <= alarmHit;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // 12h mapping done directly on the BCD pair: 00->12, 13..19->01..07, 20..23->08..11.
   always_comb begin
      dispHr = hrR;
      if (mode_12h) begin
         case (hrR[7:4])
            4'd0:    if (hrR[3:0] == 4'd0) dispHr = 8'h12;
            4'd1:    if (hrR[3:0] >= 4'd3) dispHr = {4'd0, hrR[3:0] - 4'd2};
            4'd2:    dispHr = (hrR[3:0] <= 4'd1) ? {4'd0, hrR[3:0] + 4'd8}
                                                 : {4'd1, hrR[3:0] - 4'd2};
            default: dispHr = hrR;
         endcase
      end
   end

   assign pm     = (hrR[7:4] == 4'd2) || (hrR[7:4] == 4'd1 && hrR[3:0] >= 4'd2);
   assign sec_lo = secR[3:0];
   assign sec_hi = secR[7:4];
   assign min_lo = minR[3:0];
   assign min_hi = minR[7:4];
   assign hr_lo  = dispHr[3:0];
   assign hr_hi  = dispHr[7:4];

endmodule
